cd_sector_sync: RTL and testbench

- Front-end stage between the CD drive data port and the CD block's `CD_D`/`CD_CK` consumer logic.
- Deserialises the drive's 16-bit word stream and detects the 12-byte sector sync pattern.
- Keeps sector framing with a flywheel, extracts the sector header and emits indexed words with sector-start/end strobes.
- Output goes to the CD block's buffer-write path.

---
 rtl/cd_sector_sync.sv | 247 ++++++++++++++++++++++++
 tb/tb_cd_sector_sync.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cd_sector_sync.sv
// rtl/cd_sector_sync.sv - CD sector sync detector, flywheel framer and header extractor
//
// Ports:
//   CLK, RST (sync, active-high), CE (clock enable for all state)
//   CD_D[15:0]   drive data word, low byte first in stream order
//   CD_CK        asynchronous drive word strobe, one word per rising edge
//   OUT_D[15:0]  emitted sector word (descrambled from IDX 6 when enabled)
//   OUT_VALID    one-CE-cycle pulse per emitted word
//   OUT_IDX[10:0] word index within the sector
//   SECT_START / SECT_END  strobes with IDX 0 / IDX SECT_WORDS-1
//   HDR_MSF[23:0], HDR_MODE[7:0], HDR_VALID  header fields, updated at IDX 7
//   LOCK         high while framing is locked
//
// Optional: define CD_DESCRAMBLE_EN to descramble IDX 6..SECT_WORDS-1 with the
// x^15+x+1 keystream (seed 0x0001, reloaded at IDX 0).

module cd_sector_sync #(
    parameter int SECT_WORDS = 1176,
    parameter int MISS_MAX   = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE,
    input  logic [15:0] CD_D,
    input  logic        CD_CK,
    output logic [15:0] OUT_D,
    output logic        OUT_VALID,
    output logic [10:0] OUT_IDX,
    output logic        SECT_START,
    output logic        SECT_END,
    output logic [23:0] HDR_MSF,
    output logic [7:0]  HDR_MODE,
    output logic        HDR_VALID,
    output logic        LOCK
);

    localparam int          MW       = (MISS_MAX < 2) ? 1 : $clog2(MISS_MAX + 1);
    localparam logic [MW:0] MISS_LIM = (MW + 1)'(MISS_MAX);
    localparam logic [10:0] IDX_LAST = 11'(SECT_WORDS - 1);

    typedef enum logic {ST_HUNT, ST_LOCKED} state_t;

    function automatic logic [15:0] sync_word(input logic [2:0] i);
        case (i)
            3'd0:    sync_word = 16'hFF00;
            3'd5:    sync_word = 16'h00FF;
            default: sync_word = 16'hFFFF;
        endcase
    endfunction

    state_t        state, state_nx;

    logic          ck_s1, ck_s2, ck_s3;
    logic          ck_rise;
    logic          cap_v;
    logic [15:0]   cap_d;

    logic [15:0]   hist [6];        // hist[5] is the newest word
    logic [15:0]   fifo_mem [8];
    logic [2:0]    wr_ptr, rd_ptr;
    logic [3:0]    fifo_cnt;

    logic          burst_act;       // replaying the 6 sync words after lock
    logic [10:0]   emit_idx;        // index of the next word to be emitted
    logic [MW-1:0] miss_cnt;
    logic          sect_bad;

    logic          sync_hit;
    logic          emit_v;
    logic [15:0]   emit_raw;
    logic [15:0]   emit_d;
    logic          mism;
    logic          bad_now;
    logic [MW:0]   miss_inc;
    logic          lose_lock;
    logic          push, pop;

    assign ck_rise = ck_s2 & ~ck_s3;
    assign LOCK    = (state == ST_LOCKED);

    // The word arriving now completes the pattern when the five older history
    // entries plus this word line up with the sync sequence.
    always_comb begin
        sync_hit = cap_v && (cap_d == 16'h00FF) && (hist[1] == 16'hFF00);
        for (int i = 2; i < 6; i++) begin
            if (hist[i] != 16'hFFFF) sync_hit = 1'b0;
        end
    end

    always_comb begin
        emit_v    = (state == ST_LOCKED) && (burst_act || (fifo_cnt != 4'd0));
        emit_raw  = burst_act ? sync_word(emit_idx[2:0]) : fifo_mem[rd_ptr];
        mism      = (emit_idx < 11'd6) && (emit_raw != sync_word(emit_idx[2:0]));
        bad_now   = ((emit_idx == 11'd0) ? 1'b0 : sect_bad) | mism;
        miss_inc  = {1'b0, miss_cnt} + 1'b1;
        lose_lock = emit_v && (emit_idx == 11'd5) && bad_now && (miss_inc >= MISS_LIM);
        push      = (state == ST_LOCKED) && cap_v && !lose_lock;
        pop       = emit_v && !burst_act;
    end

`ifdef CD_DESCRAMBLE_EN
    logic [14:0] lfsr;
    logic [14:0] lfsr_step;
    logic [15:0] ks;

    // Sixteen keystream bits per word, first bit lands in OUT_D[0].
    always_comb begin
        logic [14:0] l;
        l  = lfsr;
        ks = '0;
        for (int i = 0; i < 16; i++) begin
            ks[i] = l[0];
            l     = {l[0] ^ l[1], l[14:1]};
        end
        lfsr_step = l;
    end

    assign emit_d = (emit_idx >= 11'd6) ? (emit_raw ^ ks) : emit_raw;

    always_ff @(posedge CLK) begin
        if (RST) begin
            lfsr <= 15'h0001;
        end else if (CE && emit_v) begin
            if (emit_idx == 11'd0)
                lfsr <= 15'h0001;
            else if (emit_idx >= 11'd6)
                lfsr <= lfsr_step;
        end
    end
`else
    assign emit_d = emit_raw;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            ST_HUNT:   if (sync_hit) state_nx = ST_LOCKED;
            ST_LOCKED: if (lose_lock) state_nx = ST_HUNT;
            default:   state_nx = ST_HUNT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST)
            state <= ST_HUNT;
        else if (CE)
            state <= state_nx;
    end

    always_ff @(posedge CLK) begin
        if (CE && push) fifo_mem[wr_ptr] <= cap_d;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ck_s1     <= 1'b0;
            ck_s2     <= 1'b0;
            ck_s3     <= 1'b0;
            cap_v     <= 1'b0;
            cap_d     <= '0;
            for (int i = 0; i < 6; i++) hist[i] <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            burst_act <= 1'b0;
            emit_idx  <= '0;
            miss_cnt  <= '0;
            sect_bad  <= 1'b0;
        end else if (CE) begin
            ck_s1 <= CD_CK;
            ck_s2 <= ck_s1;
            ck_s3 <= ck_s2;
            cap_v <= ck_rise;
            if (ck_rise) cap_d <= CD_D;

            if (state == ST_HUNT && cap_v) begin
                for (int i = 0; i < 5; i++) hist[i] <= hist[i + 1];
                hist[5] <= cap_d;
            end else if (lose_lock) begin
                for (int i = 0; i < 6; i++) hist[i] <= '0;
            end

            // Anything still queued when lock is lost belongs to a sector we
            // are abandoning, so it is dropped.
            if (lose_lock) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                fifo_cnt <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 3'd1;
                if (pop)  rd_ptr <= rd_ptr + 3'd1;
                if (push && !pop)
                    fifo_cnt <= fifo_cnt + 4'd1;
                else if (pop && !push)
                    fifo_cnt <= fifo_cnt - 4'd1;
            end

            if (state == ST_HUNT && sync_hit) begin
                burst_act <= 1'b1;
                emit_idx  <= '0;
                miss_cnt  <= '0;
                sect_bad  <= 1'b0;
            end else if (emit_v) begin
                emit_idx <= (emit_idx == IDX_LAST) ? 11'd0 : emit_idx + 11'd1;
                sect_bad <= bad_now;
                if (emit_idx == 11'd5) begin
                    burst_act <= 1'b0;
                    if (!bad_now)
                        miss_cnt <= '0;
                    else if (lose_lock)
                        miss_cnt <= '0;
                    else
                        miss_cnt <= miss_inc[MW-1:0];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            OUT_D      <= '0;
            OUT_VALID  <= 1'b0;
            OUT_IDX    <= '0;
            SECT_START <= 1'b0;
            SECT_END   <= 1'b0;
            HDR_MSF    <= '0;
            HDR_MODE   <= '0;
            HDR_VALID  <= 1'b0;
        end else if (CE) begin
            OUT_VALID  <= emit_v;
            SECT_START <= emit_v && (emit_idx == 11'd0);
            SECT_END   <= emit_v && (emit_idx == IDX_LAST);
            HDR_VALID  <= emit_v && (emit_idx == 11'd7);
            if (emit_v) begin
                OUT_D   <= emit_d;
                OUT_IDX <= emit_idx;
                if (emit_idx == 11'd6)
                    HDR_MSF[23:8] <= {emit_d[7:0], emit_d[15:8]};
                if (emit_idx == 11'd7) begin
                    HDR_MSF[7:0] <= emit_d[7:0];
                    HDR_MODE     <= emit_d[15:8];
                end
            end
        end
    end

endmodule

// File: tb/tb_cd_sector_sync.sv
// tb/tb_cd_sector_sync.sv - scoreboard bench for cd_sector_sync

module tb_cd_sector_sync;

    localparam int SW = 1176;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CE;
    logic [15:0] CD_D;
    logic        CD_CK;
    logic [15:0] OUT_D;
    logic        OUT_VALID;
    logic [10:0] OUT_IDX;
    logic        SECT_START;
    logic        SECT_END;
    logic [23:0] HDR_MSF;
    logic [7:0]  HDR_MODE;
    logic        HDR_VALID;
    logic        LOCK;

    always #5 CLK = ~CLK;

    cd_sector_sync dut (
        .CLK(CLK), .RST(RST), .CE(CE), .CD_D(CD_D), .CD_CK(CD_CK),
        .OUT_D(OUT_D), .OUT_VALID(OUT_VALID), .OUT_IDX(OUT_IDX),
        .SECT_START(SECT_START), .SECT_END(SECT_END),
        .HDR_MSF(HDR_MSF), .HDR_MODE(HDR_MODE), .HDR_VALID(HDR_VALID),
        .LOCK(LOCK)
    );

    typedef struct {
        logic [15:0] d;
        int          idx;
        logic [23:0] msf;
        logic [7:0]  mode;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [15:0] stim_q[$];
    logic [15:0] ks_tab [SW];
    logic [15:0] pat [6];
    logic [23:0] msf_m;
    logic [7:0]  mode_m;

    int n_cmp = 0;
    int n_bad = 0;
    int n_valid, n_start, n_end;
    logic [15:0] first_idx6;
    bit  got_idx6;
    bit  ce_tog = 1'b0;
    bit  ce_edge = 1'b0;
    int  ce_cnt = 0;
    int  last_rise = 0;
    bit  ck_seen = 1'b0;
    int  first_lat;
    bit  frz_chk = 1'b0;
    logic [28:0] snap;
    bit  ok;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Keystream table straight from the scrambler definition: 15-bit register,
    // seed 1, output the low bit, feed back bit0^bit1 into bit 14.
    task automatic build_ks();
        int l;
        l = 1;
        for (int k = 0; k < SW; k++) begin
            ks_tab[k] = '0;
            if (k >= 6) begin
                for (int b = 0; b < 16; b++) begin
                    ks_tab[k][b] = l[0];
                    l = (l >> 1) | (((l ^ (l >> 1)) & 1) << 14);
                end
            end
        end
    endtask

    task automatic push_exp(input logic [15:0] w, input int k);
        exp_t e;
        logic [15:0] d;
`ifdef CD_DESCRAMBLE_EN
        d = (k >= 6) ? (w ^ ks_tab[k]) : w;
`else
        d = w;
`endif
        if (k == 6) msf_m[23:8] = {d[7:0], d[15:8]};
        if (k == 7) begin
            msf_m[7:0] = d[7:0];
            mode_m     = d[15:8];
        end
        e.d = d; e.idx = k; e.msf = msf_m; e.mode = mode_m;
        exp_q.push_back(e);
    endtask

    // Word-level reference: hunt for the pattern, then number words per sector
    // and apply the three-strike flywheel rule.
    task automatic model_run();
        logic [15:0] h [6];
        bit locked, bad, m;
        int k, miss;
        locked = 1'b0; bad = 1'b0; k = 0; miss = 0;
        for (int j = 0; j < 6; j++) h[j] = '0;
        foreach (stim_q[i]) begin
            if (!locked) begin
                for (int j = 0; j < 5; j++) h[j] = h[j + 1];
                h[5] = stim_q[i];
                m = 1'b1;
                for (int j = 0; j < 6; j++) if (h[j] != pat[j]) m = 1'b0;
                if (m) begin
                    locked = 1'b1; miss = 0; bad = 1'b0;
                    for (int j = 0; j < 6; j++) push_exp(pat[j], j);
                    k = 6;
                end
            end else begin
                if (k == 0) bad = 1'b0;
                push_exp(stim_q[i], k);
                if (k < 6 && stim_q[i] != pat[k]) bad = 1'b1;
                if (k == 5) begin
                    if (bad) begin
                        miss++;
                        if (miss >= 3) begin
                            locked = 1'b0;
                            for (int j = 0; j < 6; j++) h[j] = '0;
                        end
                    end else begin
                        miss = 0;
                    end
                end
                k = (k + 1) % SW;
            end
        end
    endtask

    task automatic add_sync(input bit corrupt);
        int cj;
        cj = $urandom_range(5, 0);
        for (int j = 0; j < 6; j++) begin
            if (corrupt && j == cj)
                stim_q.push_back(pat[j] ^ (16'd1 << $urandom_range(15, 0)));
            else
                stim_q.push_back(pat[j]);
        end
    endtask

    task automatic add_payload(input int n, input bit zero);
        for (int j = 0; j < n; j++) stim_q.push_back(zero ? 16'h0000 : 16'($urandom));
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            CD_CK = ~CD_CK;
        end
        check("reset_outputs", {5'b0, OUT_VALID, SECT_START, SECT_END, HDR_VALID, LOCK,
                                OUT_D, OUT_IDX, HDR_MSF, HDR_MODE}, 64'd0);
        RST = 1'b0;
        CD_CK = 1'b0;
        exp_q.delete();
        stim_q.delete();
        n_valid = 0; n_start = 0; n_end = 0;
        got_idx6 = 1'b0; first_idx6 = '0; first_lat = -1;
        msf_m = '0; mode_m = '0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic drive_all(input int hi, input int lo_min, input int lo_max);
        foreach (stim_q[i]) begin
            CD_D  = stim_q[i];
            CD_CK = 1'b1;
            repeat (hi) @(negedge CLK);
            CD_CK = 1'b0;
            repeat ($urandom_range(lo_max, lo_min)) @(negedge CLK);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge CLK);
            n++;
        end
        repeat (20) @(negedge CLK);
        check("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        CE = 1'b1;
        forever begin
            @(negedge CLK);
            CE = ce_tog ? ~CE : 1'b1;
        end
    end

    always @(posedge CLK) begin
        ce_edge <= CE;
        if (CE && !RST) begin
            ce_cnt++;
            if (CD_CK && !ck_seen) last_rise = ce_cnt;
            ck_seen = CD_CK;
        end
    end

    always @(negedge CLK) begin
        if (ce_edge && OUT_VALID) begin
            n_valid++;
            if (SECT_START) n_start++;
            if (SECT_END) n_end++;
            if (first_lat < 0) first_lat = ce_cnt - last_rise;
            if (OUT_IDX == 11'd6 && !got_idx6) begin
                got_idx6   = 1'b1;
                first_idx6 = OUT_D;
            end
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_word: got idx=%0d d=%h, expected no word", OUT_IDX, OUT_D);
            end else begin
                mon_e = exp_q.pop_front();
                ok = (OUT_D == mon_e.d) && (int'(OUT_IDX) == mon_e.idx)
                     && (SECT_START == (mon_e.idx == 0))
                     && (SECT_END == (mon_e.idx == SW - 1))
                     && (HDR_VALID == (mon_e.idx == 7))
                     && (mon_e.idx != 7 || (HDR_MSF == mon_e.msf && HDR_MODE == mon_e.mode));
                if (!ok) begin
                    n_bad++;
                    $display("FAIL word: got d=%h idx=%0d st=%b en=%b hv=%b msf=%h mode=%h, expected d=%h idx=%0d msf=%h mode=%h",
                             OUT_D, OUT_IDX, SECT_START, SECT_END, HDR_VALID, HDR_MSF, HDR_MODE,
                             mon_e.d, mon_e.idx, mon_e.msf, mon_e.mode);
                end
            end
        end
        if (frz_chk && !ce_edge)
            check("ce_freeze", 64'({OUT_VALID, OUT_IDX, OUT_D, LOCK}), 64'(snap));
        snap = {OUT_VALID, OUT_IDX, OUT_D, LOCK};
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        pat[0] = 16'hFF00; pat[1] = 16'hFFFF; pat[2] = 16'hFFFF;
        pat[3] = 16'hFFFF; pat[4] = 16'hFFFF; pat[5] = 16'h00FF;
        build_ks();
        RST = 1'b0; CD_CK = 1'b0; CD_D = '0;

        // Latency and clock enable: CE alternates, strobe held 2 CE cycles.
        do_reset();
        ce_tog = 1'b1;
        repeat (2) @(negedge CLK);
        frz_chk = 1'b1;
        stim_q.push_back(16'h1234);
        stim_q.push_back(16'h5678);
        add_sync(1'b0);
        model_run();
        drive_all(4, 4, 4);
        wait_drain();
        frz_chk = 1'b0;
        check("latency_ce_cycles", 64'(first_lat), 64'd4);
        check("t1_lock", 64'(LOCK), 64'd1);
        check("t1_valid_count", 64'(n_valid), 64'd6);
        ce_tog = 1'b0;
        repeat (4) @(negedge CLK);

        // Lock acquisition followed by three full sectors.
        do_reset();
        for (int i = 0; i < 20; i++) stim_q.push_back(16'h1234);
        add_sync(1'b0);
        stim_q.push_back(16'h0201);
        stim_q.push_back(16'h0402);
        add_payload(SW - 8, 1'b1);
        for (int s = 0; s < 2; s++) begin
            add_sync(1'b0);
            add_payload(SW - 6, 1'b0);
        end
        model_run();
        drive_all(2, 2, 3);
        wait_drain();
        check("t2_lock", 64'(LOCK), 64'd1);
        check("t2_valid_count", 64'(n_valid), 64'd3528);
        check("t2_sect_start", 64'(n_start), 64'd3);
        check("t2_sect_end", 64'(n_end), 64'd3);
`ifdef CD_DESCRAMBLE_EN
        check("t2_idx6_word", 64'(first_idx6), 64'h8200);
`else
        check("t2_idx6_word", 64'(first_idx6), 64'h0201);
`endif
        check("t2_hdr_final", 64'({HDR_MSF, HDR_MODE}), 64'({msf_m, mode_m}));

        // Flywheel holds through two missed syncs; zero payload in sector 1.
        do_reset();
        add_sync(1'b0);
        add_payload(SW - 6, 1'b1);
        add_sync(1'b1); add_payload(SW - 6, 1'b0);
        add_sync(1'b1); add_payload(SW - 6, 1'b0);
        add_sync(1'b0); add_payload(40, 1'b0);
        model_run();
        drive_all(2, 2, 3);
        wait_drain();
        check("t3_lock", 64'(LOCK), 64'd1);
        check("t3_valid_count", 64'(n_valid), 64'(3 * SW + 46));
        check("t3_sect_start", 64'(n_start), 64'd4);
`ifdef CD_DESCRAMBLE_EN
        check("t3_idx6_zero", 64'(first_idx6), 64'h8001);
`else
        check("t3_idx6_zero", 64'(first_idx6), 64'h0000);
`endif

        // Three missed syncs drop lock after IDX 5 of the third bad sector.
        do_reset();
        add_sync(1'b0); add_payload(SW - 6, 1'b0);
        add_sync(1'b1); add_payload(SW - 6, 1'b0);
        add_sync(1'b1); add_payload(SW - 6, 1'b0);
        add_sync(1'b1); add_payload(40, 1'b0);
        model_run();
        drive_all(2, 2, 3);
        wait_drain();
        check("t4_lock", 64'(LOCK), 64'd0);
        check("t4_valid_count", 64'(n_valid), 64'(3 * SW + 6));
        check("t4_sect_end", 64'(n_end), 64'd3);

        do_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
